// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Control, instruction-memory and IF/ID signals of the fetch
//               stage, bundled with modports for the stage (slave) and its
//               surroundings (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic [63:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [63:0] if_id_pc_o;
    logic [63:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic [63:0] fetch_count_o;

    // Viewpoint of the fetch stage itself
    modport slave (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
        output if_id_valid_o, fetch_count_o
    );

    // Viewpoint of hazard unit, execute stage, memory and decode
    modport master (
        output stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
        input  if_id_valid_o, fetch_count_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, addresses a zero-latency
//               instruction memory and loads the IF/ID register, honouring
//               redirect > flush > stall priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_stage_if.slave   bus
);

    logic [63:0] r_pc;
    logic [63:0] r_if_id_pc;
    logic [63:0] r_if_id_pc4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [63:0] r_fetch_count;
    logic [63:0] w_pc_plus4;

    // Sequential PC; wraps modulo 2^64 naturally
    assign w_pc_plus4 = r_pc + 64'd4;

    // PC and IF/ID update: reset, then redirect > flush > stall > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 64'd0;
            r_if_id_pc4   <= 64'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 64'd0;
        end else if (bus.redirect_i) begin
            // Target is forced word-aligned; the slot being fetched is squashed
            r_pc          <= {bus.redirect_pc_i[63:2], 2'b00};
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (bus.flush_i) begin
            // PC holds so the current word is fetched again next cycle
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!bus.stall_i) begin
            r_pc          <= w_pc_plus4;
            r_if_id_pc    <= r_pc;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_instr <= bus.imem_rdata_i;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 64'd1;
        end
    end

    assign bus.imem_addr_o   = r_pc;
    assign bus.if_id_pc_o    = r_if_id_pc;
    assign bus.if_id_pc4_o   = r_if_id_pc4;
    assign bus.if_id_instr_o = r_if_id_instr;
    assign bus.if_id_valid_o = r_if_id_valid;
    assign bus.fetch_count_o = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction Fetch (IF) stage of the rv64i_zba pipeline.
- Owns the program counter and drives the byte address to the combinational instruction memory.
- Captures the returned 32-bit word into the IF/ID pipeline register for decode.
- Handles pipeline stall, bubble insertion (flush) and control-flow redirect from the execute stage.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, encoding placed in IF/ID on reset and on bubble (ADDI x0,x0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard stall from decode; hold PC and IF/ID.
- flush_i  input  1  insert bubble into IF/ID.
- redirect_i  input  1  taken branch or jump resolved in EX.
- redirect_pc_i  input  64  redirect target, byte address.
- imem_addr_o  output  64  byte address to instruction memory; equals PC register, combinational.
- imem_rdata_i  input  32  instruction word returned by memory in the same cycle.
- if_id_pc_o  output  64  PC of the instruction held in IF/ID.
- if_id_pc4_o  output  64  if_id_pc_o + 4, link value for JAL/JALR.
- if_id_instr_o  output  32  instruction held in IF/ID.
- if_id_valid_o  output  1  IF/ID holds a real instruction; 0 means bubble.
- fetch_count_o  output  64  count of instructions accepted into IF/ID.

Behaviour:
- Memory read is zero-latency: imem_addr_o = pc and imem_rdata_i are valid in the same cycle. The instruction reaches IF/ID one cycle after its PC is presented.
- Reset (rst=1 at clock edge, overrides everything):
  - pc <= RESET_PC
  - if_id_pc_o <= 0, if_id_pc4_o <= 0
  - if_id_instr_o <= NOP_INSTR, if_id_valid_o <= 0
  - fetch_count_o <= 0
  - imem_addr_o therefore reads RESET_PC in the first cycle after reset.
- Per-edge priority when rst=0: redirect > flush > stall > normal.
  - redirect_i=1:
    - pc <= {redirect_pc_i[63:2], 2'b00}; low two bits are silently cleared.
    - IF/ID <= bubble (if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o/if_id_pc4_o hold).
    - Count unchanged. stall_i and flush_i are ignored.
  - flush_i=1, redirect_i=0:
    - IF/ID <= bubble; pc holds, so the current word is refetched next cycle. Count unchanged.
    - stall_i is ignored for IF/ID; pc holds regardless.
  - stall_i=1, flush_i=0, redirect_i=0:
    - pc and all IF/ID outputs hold their values; count unchanged.
  - Normal (no redirect, flush or stall):
    - pc <= pc + 4
    - if_id_pc_o <= pc, if_id_pc4_o <= pc + 4
    - if_id_instr_o <= imem_rdata_i, if_id_valid_o <= 1
    - fetch_count_o <= fetch_count_o + 1
- Arithmetic: all PC additions are 64-bit modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0. fetch_count_o wraps from all-ones to 0.
- A zero word returned for an out-of-range address is passed through unmodified with valid=1. Decode owns illegal-instruction handling.
- Reset asserted mid-stall or mid-redirect takes effect at that edge; no pending state survives.
- No combinational path from stall_i, flush_i or redirect_i to any output.

Test Plan:
- Reset release, RESET_PC=64'h1000, memory words A,B,C at 0x1000/0x1004/0x1008, no control inputs:
  - imem_addr_o = 0x1000, 0x1004, 0x1008 on successive cycles.
  - IF/ID shows (0x1000,A,valid), then (0x1004,B), then (0x1008,C).
  - if_id_pc4_o = pc+4 each cycle; fetch_count_o = 1, 2, 3.
- redirect_i=1 with redirect_pc_i=64'h2002 while pc=0x1008:
  - Next cycle imem_addr_o=0x2000 and if_id_valid_o=0.
  - Following cycle IF/ID shows (0x2000, mem[0x2000]); count not incremented for the squashed slot.
- stall_i held 3 cycles with pc=0x1004 and IF/ID=(0x1000,A):
  - imem_addr_o and all IF/ID outputs unchanged for 3 cycles.
  - After release, IF/ID shows (0x1004,B).
- flush_i=1 for one cycle with pc=0x1008:
  - IF/ID becomes valid=0, instr=32'h13; pc stays 0x1008.
  - Next cycle IF/ID shows (0x1008,C) valid.
  - flush_i=1 together with stall_i=1 gives the same result.
- Simultaneous redirect_i=1, flush_i=1, stall_i=1 with target 0x3000:
  - pc=0x3000 and a bubble in IF/ID.
  - Then with rst=1 asserted mid-run: pc=RESET_PC, valid=0, instr=32'h13, count=0 after that edge.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, then run 2 normal cycles:
  - if_id_pc4_o = 0.
  - imem_addr_o = 0 on the second cycle.
